operand_entry_fsm: RTL
======================

# operand_entry_fsm

Parametrised keypad operand-entry controller and next generation of the calculator front end. It converts a stream of 4-bit key codes into N packed operands plus an operation code, and hands the completed command to the compute unit over a valid/ready handshake. It tracks the compute unit's completion and flags rejected keys. It sits between the keypad scanner/debouncer and the CORDIC/log/exp engine.

## Interface
- NUM_OPERANDS, 3, number of operand fields (1..7)
- OPERAND_W, 32, width of each operand
- DIGIT_W, 2, bits contributed per digit key (1..3); keys 0..2^DIGIT_W-1 are digits
- OP_W, 2, operation code width; value 0 = NO_OP
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- key  in  4  key code
- key_valid  in  1  one-cycle strobe, key is sampled when high
- operands  out  NUM_OPERANDS*OPERAND_W  operand i at [i*OPERAND_W +: OPERAND_W]
- operation  out  OP_W  entered operation code
- target  out  3  field being edited: 0..NUM_OPERANDS-1 = operand, NUM_OPERANDS = operation
- digit_count  out  6  digits entered in current field
- cmd_valid  out  1  command offered to compute unit
- cmd_ready  in  1  compute unit accepts command
- result_done  in  1  compute unit finished (one-cycle pulse)
- busy  out  1  high in CALC state
- key_error  out  1  one-cycle pulse per rejected key

## Operation
- Limits: OPERAND_DIGITS = ceil(OPERAND_W/DIGIT_W); OP_DIGITS = ceil(OP_W/DIGIT_W).
- Key codes: A = ESCAPE, B = BACKSPACE, C = CLEAR, D = CALCULATE, E = ENTER, F = NEGATE (see Configuration).
- States:
  - ENTRY (reset): editing.
  - ISSUE: cmd_valid=1.
  - CALC: busy=1.
- ENTRY behaviour:
  - Digit key, below limit: field <= (field << DIGIT_W) | key[DIGIT_W-1:0], truncated to field width; digit_count++.
  - Digit key at limit, or key in 0..9 that is ≥ 2^DIGIT_W: key_error, no change.
  - ENTER: requires digit_count>0, else key_error. target advances and digit_count clears. After the operation field, target wraps to 0.
  - BACKSPACE: requires digit_count>0, else key_error. Field shifts logically right by DIGIT_W (operation field: cleared to 0); digit_count--.
  - CLEAR: current field and digit_count cleared. Always accepted.
  - CALCULATE: requires operation != 0, else key_error. Goes to ISSUE.
  - ESCAPE: clears all operands, operation, target and count. Stays in ENTRY.
- ISSUE: cmd_valid held high and operands/operation frozen until cmd_valid&&cmd_ready at a clock edge, then CALC.
- CALC: result_done → ENTRY with target=0, digit_count=0, operands and operation retained for re-use/edit.
- ESCAPE in ISSUE or CALC: abort. Go to ENTRY, clear everything, drop cmd_valid. The compute unit must tolerate a withdrawn valid.
- Any other key in ISSUE/CALC: key_error, ignored.
- result_done outside CALC: ignored.
- Simultaneous cases:
  - ESCAPE and cmd_ready in ISSUE: ESCAPE wins, no transfer.
  - ESCAPE and result_done in CALC: ESCAPE wins (clear).

## Timing
- Reset values: operands=0, operation=0, target=0, digit_count=0, cmd_valid=0, busy=0, key_error=0, state ENTRY.
- reset_n low at any time, including mid-ISSUE/CALC, clears immediately.
- All outputs registered. A key sampled at edge k is reflected at edge k (visible the cycle after key_valid).
- key_error is high for exactly the cycle following the rejected key_valid.
- CALCULATE at edge k: cmd_valid=1 from edge k.
- Handshake at edge m: cmd_valid=0, busy=1 from edge m.
- result_done at edge r: busy=0 from edge r.
- Back-to-back key_valid every cycle is supported.

## Configuration
- OPERAND_NEGATE_EN defined: key F in an operand field replaces it with its two's complement modulo 2^OPERAND_W. digit_count is unchanged. F in the operation field is a key_error.
- Undefined: key F is always key_error. No negation logic is built.

## Test plan
- Defaults: keys 1,2,E,3,E,1,E,2,E,D; then cmd_ready=1 → operands[31:0]=6, [63:32]=3, [95:64]=1, operation=2. cmd_valid high one cycle before the handshake, then busy=1.
- Overflow: 17 consecutive digit-3 keys in operand 0 → value 0xFFFFFFFF, digit_count=16, key_error pulse on the 17th only.
- Errors: ENTER with 0 digits, and D with operation=0 → key_error each, state unchanged. Digit key 5 with DIGIT_W=2 → key_error.
- Backspace/clear: 2,3,B → operand 0 = 2, count 1. Then C → 0, count 0. Then B → key_error.
- Abort: ESCAPE in ISSUE with cmd_ready raised in the same cycle → no transfer, all outputs at reset values. Same test with result_done in CALC.
- OPERAND_NEGATE_EN: 1,F → operand 0 = 0xFFFFFFFF. Without the macro, F → key_error only. reset_n pulsed mid-CALC → all reset values.

Source files
------------

// File: rtl/operand_entry_fsm.sv
// operand_entry_fsm: keypad key stream -> N packed operands + op code, issued over valid/ready.
// Optional OPERAND_NEGATE_EN: key F replaces the current operand with its two's complement.
module operand_entry_fsm #(
    parameter int NUM_OPERANDS = 3,
    parameter int OPERAND_W    = 32,
    parameter int DIGIT_W      = 2,
    parameter int OP_W         = 2
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [3:0]                        key,
    input  logic                              key_valid,
    output logic [NUM_OPERANDS*OPERAND_W-1:0] operands,
    output logic [OP_W-1:0]                   operation,
    output logic [2:0]                        target,
    output logic [5:0]                        digit_count,
    output logic                              cmd_valid,
    input  logic                              cmd_ready,
    input  logic                              result_done,
    output logic                              busy,
    output logic                              key_error
);
    localparam int OPERAND_DIGITS = (OPERAND_W + DIGIT_W - 1) / DIGIT_W;
    localparam int OP_DIGITS = (OP_W + DIGIT_W - 1) / DIGIT_W;
    localparam logic [2:0] OP_FIELD = 3'(NUM_OPERANDS);
    localparam logic [3:0] K_ESC = 4'hA, K_BS = 4'hB, K_CALC = 4'hD, K_ENT = 4'hE, K_NEG = 4'hF;
    // state bits are the registered cmd_valid / busy flags
    localparam logic [1:0] ENTRY = 2'b00, ISSUE = 2'b01, CALC = 2'b10;

    logic [1:0] state, state_n;
    logic [NUM_OPERANDS*OPERAND_W-1:0] operands_n;
    logic [OP_W-1:0] operation_n, ed_op;
    logic [2:0] target_n, ed_tgt;
    logic [5:0] count_n, ed_cnt, limit;
    logic [OPERAND_W-1:0] cur, ed_fld;
    logic err_n, on_op, digit_ok, ed_err, ed_wr, ed_calc;

    assign on_op    = target == OP_FIELD;
    assign limit    = on_op ? 6'(OP_DIGITS) : 6'(OPERAND_DIGITS);
    assign digit_ok = key < 4'(1 << DIGIT_W);

    always_comb begin
        cur = '0;
        for (int i = 0; i < NUM_OPERANDS; i++)
            if (target == 3'(i)) cur = operands[i*OPERAND_W +: OPERAND_W];
    end

    // Edit decode for ENTRY; CLEAR is the all-defaults case.
    always_comb begin
        ed_wr   = 1'b1;
        ed_fld  = '0;
        ed_op   = '0;
        ed_tgt  = target;
        ed_cnt  = '0;
        ed_calc = 1'b0;
        ed_err  = 1'b0;
        if (key <= 4'd9) begin
            ed_err = !digit_ok || digit_count == limit;
            ed_fld = OPERAND_W'({cur, key[DIGIT_W-1:0]});
            ed_op  = OP_W'({operation, key[DIGIT_W-1:0]});
            ed_cnt = digit_count + 6'd1;
        end else if (key == K_ENT) begin
            ed_err = digit_count == '0;
            ed_wr  = 1'b0;
            ed_tgt = on_op ? 3'd0 : target + 3'd1;
        end else if (key == K_BS) begin
            ed_err = digit_count == '0;
            ed_fld = cur >> DIGIT_W;
            ed_cnt = digit_count - 6'd1;
        end else if (key == K_CALC) begin
            ed_err  = operation == '0;
            ed_wr   = 1'b0;
            ed_cnt  = digit_count;
            ed_calc = 1'b1;
        end else if (key == K_NEG) begin
`ifdef OPERAND_NEGATE_EN
            ed_err = on_op;
            ed_fld = -cur;
            ed_cnt = digit_count;
`else
            ed_err = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ENTRY;
            operands    <= '0;
            operation   <= '0;
            target      <= '0;
            digit_count <= '0;
            key_error   <= 1'b0;
        end else begin
            state       <= state_n;
            operands    <= operands_n;
            operation   <= operation_n;
            target      <= target_n;
            digit_count <= count_n;
            key_error   <= err_n;
        end
    end

    always_comb begin
        state_n     = state;
        operands_n  = operands;
        operation_n = operation;
        target_n    = target;
        count_n     = digit_count;
        err_n       = 1'b0;
        if (key_valid && key == K_ESC) begin
            state_n     = ENTRY;
            operands_n  = '0;
            operation_n = '0;
            target_n    = '0;
            count_n     = '0;
        end else if (state == ISSUE) begin
            err_n   = key_valid;
            state_n = cmd_ready ? CALC : ISSUE;
        end else if (state == CALC) begin
            err_n = key_valid;
            if (result_done) begin
                state_n  = ENTRY;
                target_n = '0;
                count_n  = '0;
            end
        end else if (key_valid) begin
            err_n = ed_err;
            if (!ed_err) begin
                state_n  = ed_calc ? ISSUE : ENTRY;
                target_n = ed_tgt;
                count_n  = ed_cnt;
                if (ed_wr && on_op) operation_n = ed_op;
                for (int i = 0; i < NUM_OPERANDS; i++)
                    if (ed_wr && !on_op && target == 3'(i)) operands_n[i*OPERAND_W +: OPERAND_W] = ed_fld;
            end
        end
    end

    always_comb begin
        cmd_valid = state[0];
        busy      = state[1];
    end
endmodule
